// File: rtl/adder_window_sequencer.sv
// ---------------------------------------------------------------------------
// adder_window_sequencer
//
// Sequential front end for the external combinational N-input signed adder.
// Collects NUM_INPUTS signed words (one per cycle), presents them packed on
// add_in_data, registers the adder's combinational result and offers it on a
// valid/ready output. Counts completed output handshakes for host status.
//
// Optional build macro: ADDER_SEQ_RELU_EN
//   defined   -> a negative adder result is replaced by 0 at capture
//   undefined -> the raw adder result is captured
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   flush          synchronous abort of the current window (highest priority)
//   in_data/in_valid/in_ready      input word stream
//   add_in_data    packed window to the adder, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   add_out_data   combinational sum returned by the adder
//   out_data/out_valid/out_ready   registered window sum handshake
//   win_count      completed output handshakes, modulo 2^16
//   busy           state is not LOAD or slot count is nonzero
// ---------------------------------------------------------------------------
module adder_window_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] add_in_data,
    input  logic [31:0]                      add_out_data,
    output logic [31:0]                      out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [15:0]                      win_count,
    output logic                             busy
);

    localparam int CNT_W = $clog2(NUM_INPUTS);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SUM  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                                   state_q, state_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    // Packed so that element i lands exactly at bits [i*DATA_WIDTH +: DATA_WIDTH].
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]    slot_q, slot_d;
    logic [31:0]                              out_data_q, out_data_d;
    logic                                     out_valid_q, out_valid_d;
    logic [15:0]                              win_count_q, win_count_d;
    logic [31:0]                              captured_sum;

`ifdef ADDER_SEQ_RELU_EN
    assign captured_sum = add_out_data[31] ? 32'd0 : add_out_data;
`else
    assign captured_sum = add_out_data;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case/if tree leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        win_count_d = win_count_q;

        if (flush) begin
            // Abort wins over every handshake in the same cycle, including out_ready.
            state_d     = LOAD;
            cnt_d       = '0;
            slot_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        slot_d[cnt_q] = in_data;
                        if (cnt_q == CNT_W'(NUM_INPUTS - 1)) begin
                            cnt_d   = '0;
                            state_d = SUM;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                SUM: begin
                    out_data_d  = captured_sum;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        win_count_d = win_count_q + 16'd1;
                        slot_d      = '0;
                        state_d     = LOAD;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // NOTE: the slot array is reset along with the control state because the
    // adder input bus is architecturally required to read as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            slot_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            win_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            win_count_q <= win_count_d;
        end
    end

    // in_ready is a decode of the state register only: no path from in_valid or out_ready.
    assign in_ready    = (state_q == LOAD);
    assign busy        = (state_q != LOAD) || (cnt_q != '0);
    assign add_in_data = slot_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign win_count   = win_count_q;

endmodule

// File: tb/tb_adder_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adder_window_sequencer
//
// Directed self-checking bench for adder_window_sequencer with a behavioural
// model of the combinational adder attached to add_in_data/add_out_data.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at the same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_adder_window_sequencer;

    localparam int DW = 32;
    localparam int NI = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [NI*DW-1:0] add_in_data;
    logic [31:0]      add_out_data;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      win_count;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_window_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .add_in_data  (add_in_data),
        .add_out_data (add_out_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .win_count    (win_count),
        .busy         (busy)
    );

    // External adder model: modulo-2^32 sum of all slots.
    always_comb begin
        add_out_data = '0;
        for (int i = 0; i < NI; i++) add_out_data = add_out_data + add_in_data[i*DW +: DW];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream NI words back-to-back: first, first+inc, ...
    task automatic load_window(input logic [31:0] first, input logic [31:0] inc);
        for (int i = 0; i < NI; i++) begin
            in_data  = first + inc * i;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"},  out_data,           32'd0);
        check({tag, "_win_count"}, {16'd0, win_count}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_add_in_zero"}, {31'd0, (add_in_data == '0)}, 32'd1);
    endtask

    logic [31:0] exp_neg;

    initial begin
        rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // --- Window 1..9, out_ready high: 2-cycle in_ready gap, sum 45.
        out_ready = 1'b1;
        load_window(32'd1, 32'd1);
        check("t1_sum_in_ready",  {31'd0, in_ready},  32'd0);
        check("t1_sum_out_valid", {31'd0, out_valid}, 32'd0);
        check("t1_sum_busy",      {31'd0, busy},      32'd1);
        check("t1_slot0",         add_in_data[0*DW +: DW], 32'd1);
        check("t1_slot8",         add_in_data[8*DW +: DW], 32'd9);
        tick();
        check("t1_hold_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_hold_out_data",  out_data,           32'd45);
        check("t1_hold_in_ready",  {31'd0, in_ready},  32'd0);
        tick();
        check("t1_done_out_valid", {31'd0, out_valid}, 32'd0);
        check("t1_done_in_ready",  {31'd0, in_ready},  32'd1);
        check("t1_done_win_count", {16'd0, win_count}, 32'd1);
        check("t1_done_slots_clr", {31'd0, (add_in_data == '0)}, 32'd1);

        // --- Nine 0xFFFFFFFF words: raw sum 0xFFFFFFF7, or 0 with ReLU.
`ifdef ADDER_SEQ_RELU_EN
        exp_neg = 32'd0;
`else
        exp_neg = 32'hFFFF_FFF7;
`endif
        load_window(32'hFFFF_FFFF, 32'd0);
        tick();
        check("t2_out_valid", {31'd0, out_valid}, 32'd1);
        check("t2_out_data",  out_data,           exp_neg);
        tick();
        check("t2_win_count", {16'd0, win_count}, 32'd2);

        // --- Window 1..9 with out_ready low for 5 HOLD cycles.
        out_ready = 1'b0;
        load_window(32'd1, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("t3_hold_out_data",  out_data,           32'd45);
            check("t3_hold_in_ready",  {31'd0, in_ready},  32'd0);
            check("t3_hold_win_count", {16'd0, win_count}, 32'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_win_count", {16'd0, win_count}, 32'd3);
        check("t3_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("t3_win_count_once", {16'd0, win_count}, 32'd3);

        // --- Four words, flush (with a word presented), then 10..18.
        for (int i = 1; i <= 4; i++) begin
            in_data = i; in_valid = 1'b1; tick();
        end
        check("t4_busy_loaded", {31'd0, busy}, 32'd1);
        flush = 1'b1; in_data = 32'd99; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_busy_after_flush", {31'd0, busy}, 32'd0);
        check("t4_slots_clear", {31'd0, (add_in_data == '0)}, 32'd1);
        out_ready = 1'b1;
        in_data = 32'd10; in_valid = 1'b1; tick();
        check("t4_first_slot0", add_in_data[0*DW +: DW], 32'd10);
        for (int i = 1; i < NI; i++) begin
            in_data = 32'd10 + i; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        tick();
        check("t4_out_data", out_data, 32'd126);
        tick();
        check("t4_win_count", {16'd0, win_count}, 32'd4);

        // --- flush together with out_ready in HOLD.
        out_ready = 1'b0;
        load_window(32'd1, 32'd1);
        tick();
        check("t5_in_hold", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        check("t5_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_win_count", {16'd0, win_count}, 32'd4);
        check("t5_in_ready",  {31'd0, in_ready},  32'd1);
        check("t5_busy",      {31'd0, busy},      32'd0);

        // --- Asynchronous reset after six words, then a window of 2s.
        for (int i = 0; i < 6; i++) begin
            in_data = 32'd7; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_values("async_rst");
        #1 rst = 1'b0;
        tick();
        out_ready = 1'b1;
        load_window(32'd2, 32'd0);
        tick();
        check("t6_out_data", out_data, 32'd18);
        tick();
        check("t6_win_count", {16'd0, win_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
